// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control path:
// state encoding, opcode patterns and the control-field encodings.
package legv8_pkg;

  localparam int OPC_BITS = 11;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_EXEC_I = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_MEM_WR = 4'd6,
    ST_WB_ALU = 4'd7,
    ST_WB_MEM = 4'd8,
    ST_BRANCH = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_MEM = 3'd2,
    CLS_BR  = 3'd3,
    CLS_ILL = 3'd4
  } opc_class_t;

  localparam logic [1:0] SEU_B  = 2'b00;
  localparam logic [1:0] SEU_CB = 2'b01;
  localparam logic [1:0] SEU_I  = 2'b10;
  localparam logic [1:0] SEU_D  = 2'b11;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;

  localparam logic [10:0] MASK_FULL = 11'b11111111111;
  localparam logic [10:0] MASK_IMM  = 11'b11111111110;
  localparam logic [10:0] MASK_CB   = 11'b11111111000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADDI = 11'b10010001000;
  localparam logic [10:0] OPC_SUBI = 11'b11010001000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_B    = 11'b00010100000;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100000;
  localparam logic [10:0] OPC_CBNZ = 11'b10110101000;

  function automatic logic opc_match(input logic [10:0] opc,
                                     input logic [10:0] value,
                                     input logic [10:0] mask);
    return ((opc & mask) == (value & mask));
  endfunction

endpackage

// File: rtl/legv8_opc_decode.sv
// Combinational opcode classifier: maps IR[31:21] to an instruction class,
// the immediate format and the few flags the sequencer needs later.
module legv8_opc_decode
  import legv8_pkg::*;
(
  input  logic [OPC_BITS-1:0] opcode,
  output opc_class_t          opc_class,
  output logic [1:0]          seu_op,
  output logic                is_load,
  output logic                is_cbnz,
  output logic                illegal
);

  // priority match of the supported opcodes; R-type carries no immediate
  always_comb begin
    opc_class = CLS_ILL;
    seu_op    = SEU_B;
    is_load   = 1'b0;
    is_cbnz   = 1'b0;
    illegal   = 1'b0;
    if (opc_match(opcode, OPC_ADD, MASK_FULL) || opc_match(opcode, OPC_SUB, MASK_FULL) ||
        opc_match(opcode, OPC_AND, MASK_FULL) || opc_match(opcode, OPC_ORR, MASK_FULL)) begin
      opc_class = CLS_R;
      seu_op    = SEU_D;
    end else if (opc_match(opcode, OPC_ADDI, MASK_IMM) || opc_match(opcode, OPC_SUBI, MASK_IMM)) begin
      opc_class = CLS_I;
      seu_op    = SEU_I;
    end else if (opc_match(opcode, OPC_LDUR, MASK_FULL)) begin
      opc_class = CLS_MEM;
      seu_op    = SEU_D;
      is_load   = 1'b1;
    end else if (opc_match(opcode, OPC_STUR, MASK_FULL)) begin
      opc_class = CLS_MEM;
      seu_op    = SEU_D;
    end else if (opc_match(opcode, OPC_B, MASK_B)) begin
      opc_class = CLS_BR;
      seu_op    = SEU_B;
    end else if (opc_match(opcode, OPC_CBZ, MASK_CB)) begin
      opc_class = CLS_BR;
      seu_op    = SEU_CB;
    end else if (opc_match(opcode, OPC_CBNZ, MASK_CB)) begin
      opc_class = CLS_BR;
      seu_op    = SEU_CB;
      is_cbnz   = 1'b1;
    end else begin
      illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_mc_control.sv
// Multi-cycle LEGv8 sequencer. Outputs are decoded from the state register and
// the opcode flags captured in DECODE; all outputs are forced low during reset.
module legv8_mc_control
  import legv8_pkg::*;
#(
  parameter int OPC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       seu_op,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg2_loc,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal
);

  state_t     state_r, state_s;
  logic [1:0] seu_op_r;
  logic       is_load_r, is_cbnz_r, illegal_r;

  opc_class_t dec_class_s;
  logic [1:0] dec_seu_s;
  logic       dec_load_s, dec_cbnz_s, dec_illegal_s;

  logic [1:0] alu_op_s, pc_src_s;
  logic       alu_src_s, reg2_loc_s, mem_read_s, mem_write_s, ir_write_s;
  logic       pc_write_s, reg_write_s, mem_to_reg_s;

  legv8_opc_decode u_decode (
    .opcode    (opcode[OPC_W-1 -: OPC_BITS]),
    .opc_class (dec_class_s),
    .seu_op    (dec_seu_s),
    .is_load   (dec_load_s),
    .is_cbnz   (dec_cbnz_s),
    .illegal   (dec_illegal_s)
  );

  // state register plus the decode results captured in DECODE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_FETCH;
      seu_op_r  <= SEU_B;
      is_load_r <= 1'b0;
      is_cbnz_r <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_r == ST_DECODE) begin
        seu_op_r  <= dec_seu_s;
        is_load_r <= dec_load_s;
        is_cbnz_r <= dec_cbnz_s;
        if (dec_illegal_s) begin
          illegal_r <= 1'b1;
        end
      end
    end
  end

  // next-state and per-state control decode
  always_comb begin
    state_s      = state_r;
    alu_src_s    = 1'b0;
    alu_op_s     = ALU_ADD;
    reg2_loc_s   = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    pc_write_s   = 1'b0;
    pc_src_s     = PC_SEQ;
    reg_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s = 1'b1;
          pc_write_s = 1'b1;
          state_s    = ST_DECODE;
        end else begin
          state_s    = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (dec_class_s)
          CLS_R:   state_s = ST_EXEC_R;
          CLS_I:   state_s = ST_EXEC_I;
          CLS_MEM: state_s = ST_ADDR;
          CLS_BR:  state_s = ST_BRANCH;
          default: state_s = ST_HALT;
        endcase
      end
      ST_EXEC_R: begin
        alu_op_s = ALU_FUNCT;
        state_s  = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_s = 1'b1;
        alu_op_s  = ALU_FUNCT;
        state_s   = ST_WB_ALU;
      end
      ST_ADDR: begin
        alu_src_s  = 1'b1;
        reg2_loc_s = 1'b1;
        if (is_load_r) begin
          state_s = ST_MEM_RD;
        end else begin
          state_s = ST_MEM_WR;
        end
      end
      ST_MEM_RD: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          state_s = ST_WB_MEM;
        end else begin
          state_s = ST_MEM_RD;
        end
      end
      ST_MEM_WR: begin
        mem_write_s = 1'b1;
        if (mem_ready) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_MEM_WR;
        end
      end
      ST_WB_ALU: begin
        reg_write_s = 1'b1;
        state_s     = ST_FETCH;
      end
      ST_WB_MEM: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        state_s      = ST_FETCH;
      end
      ST_BRANCH: begin
        reg2_loc_s = 1'b1;
        alu_op_s   = ALU_PASS_B;
        pc_src_s   = PC_BRANCH;
        // B is the only branch format decoded with the SEU_B immediate
        if (seu_op_r == SEU_B) begin
          pc_write_s = 1'b1;
        end else if (is_cbnz_r) begin
          pc_write_s = ~zero;
        end else begin
          pc_write_s = zero;
        end
        state_s = ST_FETCH;
      end
      ST_HALT: begin
        state_s = ST_HALT;
      end
      default: begin
        state_s = ST_HALT;
      end
    endcase
  end

  // the decoded format is visible in DECODE itself, then held until the next DECODE
  assign seu_op     = !rst_n ? 2'b00 : ((state_r == ST_DECODE) ? dec_seu_s : seu_op_r);
  assign alu_src    = rst_n & alu_src_s;
  assign alu_op     = rst_n ? alu_op_s : 2'b00;
  assign reg2_loc   = rst_n & reg2_loc_s;
  assign mem_read   = rst_n & mem_read_s;
  assign mem_write  = rst_n & mem_write_s;
  assign ir_write   = rst_n & ir_write_s;
  assign pc_write   = rst_n & pc_write_s;
  assign pc_src     = rst_n ? pc_src_s : 2'b00;
  assign reg_write  = rst_n & reg_write_s;
  assign mem_to_reg = rst_n & mem_to_reg_s;
  assign illegal    = rst_n & illegal_r;

endmodule

// File: tb/tb_legv8_mc_control.sv
// Directed cycle-by-cycle bench for legv8_mc_control; every output is packed
// into one vector and compared against hand-computed per-cycle expectations.
module tb_legv8_mc_control;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  seu_op;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        reg2_loc;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        reg_write;
  logic        mem_to_reg;
  logic        illegal;

  int checks;
  int failures;

  // packed layout: seu(2) alu_src alu_op(2) reg2_loc mem_read mem_write ir_write pc_write pc_src(2) reg_write mem_to_reg illegal
  localparam logic [14:0] ALL   = 15'h7FFF;
  localparam logic [14:0] NOSEU = 15'h1FFF;

  legv8_mc_control #(.OPC_W(11)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .seu_op     (seu_op),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg2_loc   (reg2_loc),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] exp, input logic [14:0] mask);
    logic [14:0] obs;
    #1;
    obs = {seu_op, alu_src, alu_op, reg2_loc, mem_read, mem_write, ir_write,
           pc_write, pc_src, reg_write, mem_to_reg, illegal};
    checks++;
    assert ((obs & mask) === (exp & mask)) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs & mask, exp & mask);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    opcode    = 11'b00000000000;
    zero      = 1'b0;
    mem_ready = 1'b0;

    tick(); tick();
    chk("reset_hold",     15'b00_0_00_0_0_0_0_0_00_0_0_0, ALL);
    rst_n = 1'b1;
    chk("fetch_wait",     15'b00_0_00_0_1_0_0_0_00_0_0_0, ALL);

    // ADDI, zero wait states
    tick(); mem_ready = 1'b1; opcode = 11'b10010001000;
    chk("addi_fetch",     15'b00_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick(); mem_ready = 1'b0;
    chk("addi_decode",    15'b10_0_00_0_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("addi_exec",      15'b10_1_10_0_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("addi_wb",        15'b10_0_00_0_0_0_0_0_00_1_0_0, ALL);

    // LDUR with two wait states in MEM_RD
    tick(); mem_ready = 1'b1; opcode = 11'b11111000010;
    chk("ldur_fetch",     15'b10_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick(); mem_ready = 1'b0;
    chk("ldur_decode",    15'b11_0_00_0_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("ldur_addr",      15'b11_1_00_1_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("ldur_rd_wait1",  15'b11_0_00_0_1_0_0_0_00_0_0_0, ALL);
    tick();
    chk("ldur_rd_wait2",  15'b11_0_00_0_1_0_0_0_00_0_0_0, ALL);
    tick(); mem_ready = 1'b1;
    chk("ldur_rd_ready",  15'b11_0_00_0_1_0_0_0_00_0_0_0, ALL);
    tick(); mem_ready = 1'b0;
    chk("ldur_wb",        15'b11_0_00_0_0_0_0_0_00_1_1_0, ALL);

    // STUR, zero wait states
    tick(); mem_ready = 1'b1; opcode = 11'b11111000000;
    chk("stur_fetch",     15'b11_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick();
    chk("stur_decode",    15'b11_0_00_0_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("stur_addr",      15'b11_1_00_1_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("stur_wr",        15'b11_0_00_0_0_1_0_0_00_0_0_0, ALL);

    // CBZ: pc_write follows zero
    tick(); opcode = 11'b10110100101;
    chk("cbz_fetch",      15'b11_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick();
    chk("cbz_decode",     15'b01_0_00_0_0_0_0_0_00_0_0_0, ALL);
    tick(); zero = 1'b1;
    chk("cbz_taken",      15'b01_0_01_1_0_0_0_1_01_0_0_0, ALL);
    zero = 1'b0;
    chk("cbz_not_taken",  15'b01_0_01_1_0_0_0_0_01_0_0_0, ALL);

    // CBNZ: inverse of CBZ
    tick(); opcode = 11'b10110101011;
    chk("cbnz_fetch",     15'b01_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick();
    chk("cbnz_decode",    15'b01_0_00_0_0_0_0_0_00_0_0_0, ALL);
    tick(); zero = 1'b0;
    chk("cbnz_taken",     15'b01_0_01_1_0_0_0_1_01_0_0_0, ALL);
    zero = 1'b1;
    chk("cbnz_not_taken", 15'b01_0_01_1_0_0_0_0_01_0_0_0, ALL);

    // B: unconditional even with zero = 0
    tick(); opcode = 11'b00010100000;
    chk("b_fetch",        15'b01_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick();
    chk("b_decode",       15'b00_0_00_0_0_0_0_0_00_0_0_0, ALL);
    tick(); zero = 1'b0;
    chk("b_branch",       15'b00_0_01_1_0_0_0_1_01_0_0_0, ALL);

    // ADD (R-type); immediate format is irrelevant so seu is masked
    tick(); opcode = 11'b10001011000;
    chk("add_fetch",      15'b00_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick();
    chk("add_decode",     15'b00_0_00_0_0_0_0_0_00_0_0_0, NOSEU);
    tick();
    chk("add_exec",       15'b00_0_10_0_0_0_0_0_00_0_0_0, NOSEU);
    tick();
    chk("add_wb",         15'b00_0_00_0_0_0_0_0_00_1_0_0, NOSEU);

    // illegal opcode: HALT is absorbing with no strobes
    tick(); opcode = 11'b00000000000;
    chk("ill_fetch",      15'b00_0_00_0_1_0_1_1_00_0_0_0, NOSEU);
    tick();
    chk("ill_decode",     15'b00_0_00_0_0_0_0_0_00_0_0_0, NOSEU);
    for (int i = 0; i < 20; i++) begin
      tick(); mem_ready = i[0]; zero = i[1];
      chk("halt", 15'b00_0_00_0_0_0_0_0_00_0_0_1, NOSEU);
    end
    rst_n = 1'b0;
    tick();
    chk("halt_reset",     15'b00_0_00_0_0_0_0_0_00_0_0_0, ALL);
    rst_n = 1'b1; mem_ready = 1'b0;
    chk("halt_refetch",   15'b00_0_00_0_1_0_0_0_00_0_0_0, ALL);

    // reset while waiting in MEM_RD
    tick(); mem_ready = 1'b1; opcode = 11'b11111000010;
    chk("rst_ldur_fetch", 15'b00_0_00_0_1_0_1_1_00_0_0_0, ALL);
    tick(); mem_ready = 1'b0;
    tick();
    chk("rst_ldur_addr",  15'b11_1_00_1_0_0_0_0_00_0_0_0, ALL);
    tick();
    chk("rst_ldur_wait",  15'b11_0_00_0_1_0_0_0_00_0_0_0, ALL);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_wait",   15'b00_0_00_0_0_0_0_0_00_0_0_0, ALL);
    rst_n = 1'b1;
    chk("rst_to_fetch",   15'b00_0_00_0_1_0_0_0_00_0_0_0, ALL);
    tick(); mem_ready = 1'b1;
    chk("rst_fetch_go",   15'b00_0_00_0_1_0_1_1_00_0_0_0, ALL);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
